// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, instruction
// field positions, opcode constants and the immediate extension helper.
package datapath_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    localparam int MAJOR_MSB = 15;
    localparam int MAJOR_LSB = 12;
    localparam int RDEST_MSB = 11;
    localparam int RDEST_LSB = 8;
    localparam int EXT_MSB   = 7;
    localparam int EXT_LSB   = 4;
    localparam int RSRC_MSB  = 3;
    localparam int RSRC_LSB  = 0;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    localparam logic [3:0] MAJOR_RTYPE = 4'b0000;
    localparam logic [3:0] MAJOR_CMP   = 4'b1011;
    localparam logic [3:0] EXT_CMP     = 4'b1011;

    function automatic logic [15:0] extend_imm(input logic [7:0] imm, input logic sign_ext);
        if (sign_ext)
            return {{8{imm[7]}}, imm};
        return {8'h00, imm};
    endfunction

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Combinational decode of a latched instruction word into ALU controls,
// immediate, compare flag and a one-hot destination register enable.
module datapath_sequencer_instr_decoder
    import datapath_sequencer_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic [15:0]         i_instr,
    output logic [7:0]          o_op_code,
    output logic                o_use_imm,
    output logic [15:0]         o_immediate,
    output logic                o_is_cmp,
    output logic [NUM_REGS-1:0] o_rdest_onehot
);

    logic [3:0] w_major;
    logic [3:0] w_rdest;
    logic [3:0] w_ext;
    logic [7:0] w_imm;
    logic       w_rtype;

    assign w_major = i_instr[MAJOR_MSB:MAJOR_LSB];
    assign w_rdest = i_instr[RDEST_MSB:RDEST_LSB];
    assign w_ext   = i_instr[EXT_MSB:EXT_LSB];
    assign w_imm   = i_instr[IMM_MSB:IMM_LSB];
    assign w_rtype = (w_major == MAJOR_RTYPE);

    // R-type carries the ALU function in ext; I-type uses the major op alone.
    assign o_op_code   = w_rtype ? {w_major, w_ext} : {w_major, 4'b0000};
    assign o_use_imm   = ~w_rtype;
    assign o_immediate = w_rtype ? 16'h0000 : extend_imm(w_imm, IMM_SIGNED);
    assign o_is_cmp    = w_rtype ? (w_ext == EXT_CMP) : (w_major == MAJOR_CMP);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
            assign o_rdest_onehot[gi] = (w_rdest == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/datapath_sequencer.sv
// Four-state instruction sequencer for the register-file/ALU datapath.
// Define SEQ_RETIRE_COUNT_EN to build the retired-instruction counter.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [3:0]          a_select,
    output logic [3:0]          b_select,
    output logic                use_imm,
    output logic [15:0]         immediate,
    output logic [7:0]          op_code,
    output logic                flags_en,
    output logic                done,
    output logic [15:0]         retire_count
);

    state_t              r_state;
    logic [15:0]         r_instr;
    logic                r_ready;
    logic [NUM_REGS-1:0] r_reg_enable;
    logic [3:0]          r_a_select;
    logic [3:0]          r_b_select;
    logic                r_use_imm;
    logic [15:0]         r_immediate;
    logic [7:0]          r_op_code;
    logic                r_flags_en;
    logic                r_done;

    logic [7:0]          w_op_code;
    logic                w_use_imm;
    logic [15:0]         w_immediate;
    logic                w_is_cmp;
    logic [NUM_REGS-1:0] w_rdest_onehot;

    datapath_sequencer_instr_decoder #(
        .NUM_REGS   (NUM_REGS),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_decoder (
        .i_instr        (r_instr),
        .o_op_code      (w_op_code),
        .o_use_imm      (w_use_imm),
        .o_immediate    (w_immediate),
        .o_is_cmp       (w_is_cmp),
        .o_rdest_onehot (w_rdest_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_instr      <= '0;
            r_ready      <= 1'b1;
            r_reg_enable <= '0;
            r_a_select   <= '0;
            r_b_select   <= '0;
            r_use_imm    <= 1'b0;
            r_immediate  <= '0;
            r_op_code    <= '0;
            r_flags_en   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Write strobes are single-cycle; only the EXECUTE arm raises them.
            r_reg_enable <= '0;
            r_flags_en   <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr <= instr;
                        r_ready <= 1'b0;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a_select  <= r_instr[RDEST_MSB:RDEST_LSB];
                    r_b_select  <= r_instr[RSRC_MSB:RSRC_LSB];
                    r_use_imm   <= w_use_imm;
                    r_immediate <= w_immediate;
                    r_op_code   <= w_op_code;
                    r_state     <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_reg_enable <= w_is_cmp ? '0 : w_rdest_onehot;
                    r_flags_en   <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign reg_enable  = r_reg_enable;
    assign a_select    = r_a_select;
    assign b_select    = r_b_select;
    assign use_imm     = r_use_imm;
    assign immediate   = r_immediate;
    assign op_code     = r_op_code;
    assign flags_en    = r_flags_en;
    assign done        = r_done;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] r_retire_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retire_count <= '0;
        else if (r_state == ST_WRITEBACK)
            r_retire_count <= r_retire_count + 16'd1;
    end

    assign retire_count = r_retire_count;
`else
    assign retire_count = 16'h0000;
`endif

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control FSM that accepts one 16-bit instruction word at a time and sequences the register-file / ALU / flags datapath.
- Drives the register write enables, A/B read selects, immediate path, ALU opcode and flags-register enable.
- Sits between the instruction source (memory or testbench) and the register-file/ALU datapath wrapper; one instruction in flight at a time.

Parameters:
- NUM_REGS, 16, number of registers; width of reg_enable.
- IMM_SIGNED, 1, 1 = sign-extend 8-bit immediates to 16 bits; 0 = zero-extend.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  16  instruction word; valid when instr_valid=1
- instr_valid  in  1  source has an instruction
- instr_ready  out  1  sequencer can accept an instruction
- reg_enable  out  NUM_REGS  one-hot register write enable
- a_select  out  4  read select A (destination register Rdest)
- b_select  out  4  read select B (source register Rsrc)
- use_imm  out  1  1 = ALU B operand is immediate
- immediate  out  16  extended immediate
- op_code  out  8  ALU opcode
- flags_en  out  1  flags register load enable
- done  out  1  one-cycle pulse on writeback
- retire_count  out  16  retired-instruction counter (see Optional Feature)

Behaviour:
- Instruction fields:
  - [15:12] major op; [11:8] Rdest; [7:4] ext; [3:0] Rsrc.
  - Immediate forms take imm = [7:0].
- Decode:
  - Major op 4'b0000 (R-type): op_code = {major, ext}, use_imm = 0.
  - Any other major op (I-type): op_code = {major, 4'b0000}, use_imm = 1, immediate = ext(imm) per IMM_SIGNED.
- Compare:
  - R-type ext 4'b1011 and I-type major 4'b1011 are compares.
  - Compares write flags only; reg_enable stays 0 at writeback.
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr into an internal register and go to DECODE.
  - DECODE: drive selects, use_imm, immediate and op_code from the latched word; go to EXECUTE.
  - EXECUTE: hold all datapath controls for one ALU settle cycle; go to WRITEBACK.
  - WRITEBACK: hold controls. Assert reg_enable = one-hot(Rdest) (zero for a compare), flags_en = 1 and done = 1 for exactly one cycle; go to IDLE.
- Latency:
  - Handshake at edge N; write-back takes effect on edge N+3; instr_ready high again in cycle N+3 after WRITEBACK.
  - Throughput is one instruction per 4 cycles.
- Output rules:
  - instr_ready is low in every state except IDLE; instr changes outside IDLE are ignored.
  - Outside WRITEBACK, reg_enable = 0, flags_en = 0 and done = 0.
  - Selects, op_code, use_imm and immediate are registered. They hold their last decoded values in IDLE and never glitch mid-instruction.
- Reset (asynchronous, any state):
  - State returns to IDLE; all outputs 0 except instr_ready = 1; latched instruction 0; retire_count 0.
  - Reset asserted during WRITEBACK suppresses that write.
- Rdest = Rsrc is legal; no special handling.
- An instruction presented while in WRITEBACK waits until IDLE.

Optional Feature:
- Macro: SEQ_RETIRE_COUNT_EN.
- Defined: retire_count increments by 1 on every WRITEBACK cycle, compares included. Wraps 16'hFFFF -> 16'h0000. Cleared by reset.
- Undefined: retire_count is tied to 16'h0000 and no counter flops are built.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, DECODE = 2'd1, EXECUTE = 2'd2, WRITEBACK = 2'd3.
  - Field bit positions.
  - Major-op constants: R-type = 4'b0000, CMP = 4'b1011.
  - CMP ext code.
- One natural sub-module, instr_decoder: combinational map of the latched instruction to op_code, use_imm, immediate, is_cmp and a one-hot Rdest.
- The FSM and registers stay in datapath_sequencer.

Test Plan:
- Reset then idle: reset pulse -> instr_ready = 1; reg_enable, flags_en, done, op_code all 0.
- R-type ADD: instr = 16'h0253 (Rdest = 2, ext = 5, Rsrc = 3), valid for 1 cycle -> a_select = 2, b_select = 3, op_code = 8'h05, use_imm = 0. Three edges later reg_enable = 16'h0004, flags_en = 1, done = 1 for one cycle.
- I-type sign extend: instr = 16'h51F6, IMM_SIGNED = 1 -> use_imm = 1, immediate = 16'hFFF6, op_code = 8'h50, reg_enable = 16'h0002 at writeback. With IMM_SIGNED = 0 -> immediate = 16'h00F6.
- Compare: instr = 16'h04B7 -> WRITEBACK with flags_en = 1 and reg_enable = 16'h0000.
- Back-pressure: instr_valid held high with changing instr during DECODE/EXECUTE -> instr_ready = 0, latched word unchanged, next accept only in IDLE.
- Reset mid-operation: reset asserted in EXECUTE -> state IDLE immediately; no reg_enable or flags_en pulse. With SEQ_RETIRE_COUNT_EN, retire_count = 0; after 3 completed instructions retire_count = 3.
